// File: rtl/mbldcm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mbldcm_pkg
// Description : Shared constants and helpers for the BLDC start-up sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mbldcm_pkg;

  localparam logic [1:0] c_ADDR_FREQ    = 2'd0;
  localparam logic [1:0] c_ADDR_PWM_CMP = 2'd1;
  localparam logic [1:0] c_ADDR_CTRL    = 2'd2;
  localparam logic [1:0] c_ADDR_STATUS  = 2'd3;

  localparam int c_CTRL_ENABLE    = 0;
  localparam int c_CTRL_PHASE_LSB = 2;
  localparam int c_CTRL_W_PHASE   = 5;
  localparam int c_CTRL_DIV_LSB   = 6;
  localparam int c_CTRL_TOP_LSB   = 12;

  localparam logic [1:0] c_RESP_OK = 2'b00;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_ALIGN = 3'd1;
  localparam logic [2:0] c_ST_RAMP  = 3'd2;
  localparam logic [2:0] c_ST_RUN   = 3'd3;
  localparam logic [2:0] c_ST_STOP  = 3'd4;
  localparam logic [2:0] c_ST_ERROR = 3'd5;

  typedef struct packed {
    logic [1:0]  addr;
    logic [31:0] data;
  } busOp_t;

  function automatic busOp_t busOp(input logic [1:0] addr, input logic [31:0] data);
    busOp_t op;
    op.addr = addr;
    op.data = data;
    return op;
  endfunction

  function automatic logic [31:0] ctrlWord(input logic [15:0] top, input logic [5:0] div,
                                           input logic wPhase, input logic [2:0] phase,
                                           input logic enable);
    logic [31:0] word;
    word                          = '0;
    word[c_CTRL_ENABLE]           = enable;
    word[c_CTRL_PHASE_LSB +: 3]   = phase;
    word[c_CTRL_W_PHASE]          = wPhase;
    word[c_CTRL_DIV_LSB +: 6]     = div;
    word[c_CTRL_TOP_LSB +: 16]    = top;
    return word;
  endfunction

  // States in which a stop request forces the orderly shutdown path.
  function automatic logic isActive(input logic [2:0] state);
    return (state == c_ST_ALIGN) || (state == c_ST_RAMP) || (state == c_ST_RUN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mbldcm_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : mbldcm_seq_timer
// Description : Loadable down-counter with expire pulse for align/dwell timing.
// Revision    : 1.0 - initial release
// ============================================================================
module mbldcm_seq_timer #(
  parameter int pTimerWidth = 24
) (
  input  logic                   iClock,
  input  logic                   iReset_n,
  input  logic                   iLoad,
  input  logic [pTimerWidth-1:0] iValue,
  output logic                   oExpire,
  output logic                   oIdle
);

  localparam logic [pTimerWidth-1:0] c_ONE = {{(pTimerWidth-1){1'b0}}, 1'b1};

  logic [pTimerWidth-1:0] r_count;

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_count <= '0;
    end else if (iLoad) begin
      r_count <= iValue;
    end else if (r_count != '0) begin
      r_count <= r_count - c_ONE;
    end
  end

  // Expire fires in the last counted cycle so the caller can act on the Nth clock.
  assign oExpire = (r_count == c_ONE);
  assign oIdle   = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mbldcm_ramp_seq.sv
`default_nettype none
// ============================================================================
// Module      : mbldcm_ramp_seq
// Description : Open-loop BLDC start-up sequencer (align, ramp, run) as bus master.
// Revision    : 1.0 - initial release
// ============================================================================
module mbldcm_ramp_seq
  import mbldcm_pkg::*;
#(
  parameter logic [2:0]  pAlignPhase = 3'd3,
  parameter logic [15:0] pPwmTop     = 16'hFFFF,
  parameter logic [5:0]  pPwmDiv     = 6'd0,
  parameter int          pTimerWidth = 24
) (
  input  logic                   iClock,
  input  logic                   iReset_n,
  input  logic                   iStart,
  input  logic                   iStop,
  input  logic                   iClear,
  input  logic [31:0]            iStartPeriod,
  input  logic [31:0]            iTargetPeriod,
  input  logic [31:0]            iRampStep,
  input  logic [pTimerWidth-1:0] iDwell,
  input  logic [pTimerWidth-1:0] iAlignTime,
  input  logic [31:0]            iAlignDuty,
  input  logic [31:0]            iRunDuty,
  output logic [1:0]             oAddr,
  output logic                   oWrite,
  output logic [31:0]            oWdata,
  input  logic [1:0]             iResp,
  output logic                   oBusy,
  output logic                   oRunning,
  output logic                   oError
);

  logic [2:0]  r_state;
  logic [1:0]  r_step;
  logic [31:0] r_cur;
  logic        r_stopReq;
  logic        r_gap;

  logic [2:0]             w_nextState;
  logic [1:0]             w_nextStep;
  logic                   w_issue;
  busOp_t                 w_op;
  logic                   w_timerLoad;
  logic [pTimerWidth-1:0] w_timerValue;
  logic                   w_timerExpire;
  logic                   w_timerIdle;
  logic                   w_timerDone;
  logic                   w_curLoad;
  logic [31:0]            w_curValue;
  logic                   w_respErr;
  logic                   w_free;
  logic [31:0]            w_rampDiff;
  logic                   w_rampDone;

  mbldcm_seq_timer #(
    .pTimerWidth(pTimerWidth)
  ) u_timer (
    .iClock  (iClock),
    .iReset_n(iReset_n),
    .iLoad   (w_timerLoad),
    .iValue  (w_timerValue),
    .oExpire (w_timerExpire),
    .oIdle   (w_timerIdle)
  );

  // r_step names the next action inside a state; a write advances it at issue time.
  always_comb begin
    w_respErr    = r_gap && (iResp != c_RESP_OK) && (r_state != c_ST_ERROR);
    w_free       = !oWrite && !w_respErr;
    w_timerDone  = w_timerExpire || w_timerIdle;
    w_rampDiff   = r_cur - iTargetPeriod;
    w_rampDone   = (r_cur <= iTargetPeriod) || (w_rampDiff <= iRampStep);
    w_nextState  = r_state;
    w_nextStep   = r_step;
    w_issue      = 1'b0;
    w_op         = '0;
    w_timerLoad  = 1'b0;
    w_timerValue = iDwell;
    w_curLoad    = 1'b0;
    w_curValue   = r_cur;

    if (w_respErr) begin
      w_nextState = c_ST_ERROR;
      w_nextStep  = 2'd0;
    end else if (w_free) begin
      if (isActive(r_state) && (r_stopReq || iStop)) begin
        w_nextState = c_ST_STOP;
        w_nextStep  = 2'd0;
      end else begin
        case (r_state)
          c_ST_IDLE: begin
            if (iStart && !iStop) begin
              w_nextState = c_ST_ALIGN;
              w_nextStep  = 2'd0;
            end
          end
          c_ST_ALIGN: begin
            case (r_step)
              2'd0: begin
                w_issue    = 1'b1;
                w_op       = busOp(c_ADDR_PWM_CMP, iAlignDuty);
                w_nextStep = 2'd1;
              end
              2'd1: begin
                w_issue      = 1'b1;
                w_op         = busOp(c_ADDR_CTRL, ctrlWord(pPwmTop, pPwmDiv, 1'b1, pAlignPhase, 1'b1));
                w_timerLoad  = 1'b1;
                w_timerValue = iAlignTime;
                w_nextStep   = 2'd2;
              end
              default: begin
                if (w_timerDone) begin
                  w_nextState = c_ST_RAMP;
                  w_nextStep  = 2'd0;
                end
              end
            endcase
          end
          c_ST_RAMP: begin
            case (r_step)
              2'd0: begin
                w_issue    = 1'b1;
                w_op       = busOp(c_ADDR_FREQ, iStartPeriod);
                w_curLoad  = 1'b1;
                w_curValue = iStartPeriod;
                w_nextStep = 2'd1;
              end
              2'd1: begin
                w_issue     = 1'b1;
                w_op        = busOp(c_ADDR_CTRL, ctrlWord(pPwmTop, pPwmDiv, 1'b0, pAlignPhase, 1'b1));
                w_timerLoad = 1'b1;
                w_nextStep  = 2'd2;
              end
              default: begin
                if (w_timerDone) begin
                  w_issue   = 1'b1;
                  w_curLoad = 1'b1;
                  if (w_rampDone) begin
                    // The final FREQ write doubles as the first write of RUN.
                    w_curValue  = iTargetPeriod;
                    w_op        = busOp(c_ADDR_FREQ, iTargetPeriod);
                    w_nextState = c_ST_RUN;
                    w_nextStep  = 2'd1;
                  end else begin
                    w_curValue  = r_cur - iRampStep;
                    w_op        = busOp(c_ADDR_FREQ, r_cur - iRampStep);
                    w_timerLoad = 1'b1;
                  end
                end
              end
            endcase
          end
          c_ST_RUN: begin
            case (r_step)
              2'd1: begin
                w_issue    = 1'b1;
                w_op       = busOp(c_ADDR_PWM_CMP, iRunDuty);
                w_nextStep = 2'd2;
              end
              default: w_nextStep = 2'd3;
            endcase
          end
          c_ST_STOP: begin
            case (r_step)
              2'd0: begin
                w_issue    = 1'b1;
                w_op       = busOp(c_ADDR_PWM_CMP, 32'd0);
                w_nextStep = 2'd1;
              end
              2'd1: begin
                w_issue    = 1'b1;
                w_op       = busOp(c_ADDR_CTRL, 32'd0);
                w_nextStep = 2'd2;
              end
              default: begin
                w_nextState = c_ST_IDLE;
                w_nextStep  = 2'd0;
              end
            endcase
          end
          c_ST_ERROR: begin
            if (r_step == 2'd0) begin
              w_issue    = 1'b1;
              w_op       = busOp(c_ADDR_CTRL, 32'd0);
              w_nextStep = 2'd1;
            end else if (iClear) begin
              w_nextState = c_ST_IDLE;
              w_nextStep  = 2'd0;
            end
          end
          default: begin
            w_nextState = c_ST_IDLE;
            w_nextStep  = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state   <= c_ST_IDLE;
      r_step    <= 2'd0;
      r_cur     <= '0;
      r_stopReq <= 1'b0;
      r_gap     <= 1'b0;
      oAddr     <= '0;
      oWrite    <= 1'b0;
      oWdata    <= '0;
      oRunning  <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_step    <= w_nextStep;
      r_gap     <= oWrite;
      oWrite    <= w_issue;
      if (w_issue) begin
        oAddr  <= w_op.addr;
        oWdata <= w_op.data;
      end
      if (w_curLoad) begin
        r_cur <= w_curValue;
      end
      r_stopReq <= isActive(w_nextState) && (r_stopReq || (iStop && isActive(r_state)));
      oRunning  <= (w_nextState == c_ST_RUN) && (w_nextStep == 2'd3);
    end
  end

  assign oBusy  = (r_state != c_ST_IDLE) && (r_state != c_ST_ERROR);
  assign oError = (r_state == c_ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_mbldcm_ramp_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mbldcm_ramp_seq
// Description : Scoreboard bench for the BLDC start-up sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mbldcm_ramp_seq;

  localparam logic [31:0] c_ALIGN_CTRL = {4'h0, 16'hFFFF, 6'd0, 1'b1, 3'd3, 1'b0, 1'b1};
  localparam logic [31:0] c_RAMP_CTRL  = {4'h0, 16'hFFFF, 6'd0, 1'b0, 3'd3, 1'b0, 1'b1};

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        iReset_n, iStart, iStop, iClear;
  logic [31:0] iStartPeriod, iTargetPeriod, iRampStep, iAlignDuty, iRunDuty;
  logic [23:0] iDwell, iAlignTime;
  logic [1:0]  oAddr, iResp;
  logic        oWrite, oBusy, oRunning, oError;
  logic [31:0] oWdata;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wrCount = 0;
  int   failOn = 0;
  logic prevWrite = 1'b0;
  wr_t  expQ[$];
  int   freqCyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mbldcm_ramp_seq dut (
    .iClock(clk), .iReset_n(iReset_n), .iStart(iStart), .iStop(iStop), .iClear(iClear),
    .iStartPeriod(iStartPeriod), .iTargetPeriod(iTargetPeriod), .iRampStep(iRampStep),
    .iDwell(iDwell), .iAlignTime(iAlignTime), .iAlignDuty(iAlignDuty), .iRunDuty(iRunDuty),
    .oAddr(oAddr), .oWrite(oWrite), .oWdata(oWdata), .iResp(iResp),
    .oBusy(oBusy), .oRunning(oRunning), .oError(oError)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input logic [1:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    expQ.push_back(w);
  endtask

  // Reference write list for a complete start: align, ramp with saturation, run.
  task automatic pushStartSeq();
    logic [31:0] cur;
    pushExp(2'd1, iAlignDuty);
    pushExp(2'd2, c_ALIGN_CTRL);
    pushExp(2'd0, iStartPeriod);
    pushExp(2'd2, c_RAMP_CTRL);
    cur = iStartPeriod;
    for (int i = 0; i < 64; i++) begin
      if (cur <= iTargetPeriod || (cur - iTargetPeriod) <= iRampStep) break;
      cur = cur - iRampStep;
      pushExp(2'd0, cur);
    end
    pushExp(2'd0, iTargetPeriod);
    pushExp(2'd1, iRunDuty);
  endtask

  // Slave model and scoreboard: responds in the gap after each write.
  always @(negedge clk) begin
    if (!iReset_n) begin
      iResp     = 2'b00;
      prevWrite = 1'b0;
    end else begin
      iResp     = (prevWrite && failOn != 0 && wrCount == failOn) ? 2'b10 : 2'b00;
      prevWrite = oWrite;
      if (oWrite) begin
        wr_t w;
        wrCount++;
        if (oAddr == 2'd0) freqCyc.push_back(cyc);
        if (expQ.size() == 0) begin
          chk("unexpected_write", {30'd0, oAddr, oWdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          w = expQ.pop_front();
          chk("write_addr", {62'd0, oAddr}, {62'd0, w.a});
          chk("write_data", {32'd0, oWdata}, {32'd0, w.d});
        end
      end
    end
  end

  function automatic logic sigSel(input int s);
    case (s)
      0:       return oRunning;
      1:       return oBusy;
      default: return oError;
    endcase
  endfunction

  task automatic waitSig(input int s, input logic val, input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      if (sigSel(s) === val) break;
      @(negedge clk);
    end
    chk(tag, {63'd0, sigSel(s)}, {63'd0, val});
  endtask

  task automatic waitWrites(input int n, input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      if (wrCount >= n) break;
      @(negedge clk);
    end
    chk(tag, 64'(wrCount >= n), 64'd1);
  endtask

  task automatic pulse(input logic s, input logic p, input logic c);
    iStart = s; iStop = p; iClear = c;
    @(negedge clk);
    iStart = 1'b0; iStop = 1'b0; iClear = 1'b0;
  endtask

  task automatic setCfg(input int sp, input int tp, input int st, input int dw, input int al);
    iStartPeriod = sp; iTargetPeriod = tp; iRampStep = st;
    iDwell = 24'(dw); iAlignTime = 24'(al);
  endtask

  initial begin
    int w0;
    iReset_n = 1'b0; iStart = 1'b0; iStop = 1'b0; iClear = 1'b0; iResp = 2'b00;
    setCfg(1000, 400, 200, 50, 100);
    iAlignDuty = 32'h0000_1234; iRunDuty = 32'h0000_8000;

    // Reset state
    #100;
    chk("reset_outputs", {29'd0, oWrite, oBusy, oRunning, oError, oAddr, oWdata},
        64'd0);
    @(negedge clk);
    iReset_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("reset_no_writes", 64'(wrCount), 64'd0);

    // Full start and ramp timing
    freqCyc.delete();
    pushStartSeq();
    pulse(1'b1, 1'b0, 1'b0);
    chk("start_busy", {63'd0, oBusy}, 64'd1);
    waitSig(0, 1'b1, 3000, "full_running");
    chk("full_queue_empty", 64'(expQ.size()), 64'd0);
    chk("full_write_count", 64'(wrCount), 64'd8);
    chk("full_freq_count", 64'(freqCyc.size()), 64'd4);
    if (freqCyc.size() == 4) begin
      chk("dwell_800_600", 64'(freqCyc[2] - freqCyc[1]), 64'd50);
      chk("dwell_600_400", 64'(freqCyc[3] - freqCyc[2]), 64'd50);
      chk("dwell_first_min", 64'(freqCyc[1] - freqCyc[0] >= 50), 64'd1);
    end
    pushExp(2'd1, 32'd0);
    pushExp(2'd2, 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    waitSig(1, 1'b0, 200, "run_stop_idle");
    chk("run_stop_queue", 64'(expQ.size()), 64'd0);
    chk("run_stop_running", {63'd0, oRunning}, 64'd0);

    // Ramp saturation at target, zero align time
    setCfg(1000, 450, 300, 20, 0);
    pushStartSeq();
    pulse(1'b1, 1'b0, 1'b0);
    waitSig(0, 1'b1, 3000, "sat_running");
    chk("sat_queue_empty", 64'(expQ.size()), 64'd0);
    pushExp(2'd1, 32'd0);
    pushExp(2'd2, 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    waitSig(1, 1'b0, 200, "sat_stop_idle");

    // Stop in mid-dwell during RAMP
    setCfg(1000, 100, 100, 200, 10);
    w0 = wrCount;
    pushExp(2'd1, iAlignDuty);
    pushExp(2'd2, c_ALIGN_CTRL);
    pushExp(2'd0, 32'd1000);
    pushExp(2'd2, c_RAMP_CTRL);
    pulse(1'b1, 1'b0, 1'b0);
    waitWrites(w0 + 4, 500, "ramp_entry_writes");
    repeat (50) @(negedge clk);
    pushExp(2'd1, 32'd0);
    pushExp(2'd2, 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    waitSig(1, 1'b0, 200, "ramp_stop_idle");
    repeat (5) @(negedge clk);
    chk("ramp_stop_queue", 64'(expQ.size()), 64'd0);
    chk("ramp_stop_count", 64'(wrCount - w0), 64'd6);
    w0 = wrCount;
    pulse(1'b1, 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    chk("start_stop_same_writes", 64'(wrCount), 64'(w0));
    chk("start_stop_same_busy", {63'd0, oBusy}, 64'd0);

    // Error response on the second write
    setCfg(1000, 400, 200, 50, 100);
    failOn = wrCount + 2;
    w0 = wrCount;
    pushExp(2'd1, iAlignDuty);
    pushExp(2'd2, c_ALIGN_CTRL);
    pushExp(2'd2, 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    waitSig(2, 1'b1, 100, "err_flag");
    repeat (10) @(negedge clk);
    chk("err_queue", 64'(expQ.size()), 64'd0);
    chk("err_busy", {63'd0, oBusy}, 64'd0);
    failOn = 0;
    w0 = wrCount;
    pulse(1'b1, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    chk("err_start_ignored", 64'(wrCount), 64'(w0));
    chk("err_still_set", {63'd0, oError}, 64'd1);
    pulse(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("err_cleared", {62'd0, oError, oBusy}, 64'd0);

    // Asynchronous reset while running, then restart
    pushStartSeq();
    pulse(1'b1, 1'b0, 1'b0);
    waitSig(0, 1'b1, 3000, "pre_reset_running");
    chk("pre_reset_queue", 64'(expQ.size()), 64'd0);
    #2 iReset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {29'd0, oWrite, oBusy, oRunning, oError, oAddr, oWdata},
        64'd0);
    expQ.delete();
    @(negedge clk);
    iReset_n = 1'b1;
    repeat (5) @(negedge clk);
    pushStartSeq();
    pulse(1'b1, 1'b0, 1'b0);
    waitSig(0, 1'b1, 3000, "restart_running");
    chk("restart_queue", 64'(expQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
